reset_sequence_controller: RTL and testbench

Run-time reset controller that sits beside the power-on reset sequencer and owns reset of the interconnect, peripheral and processor domains after boot. It accepts reset requests from several sources (software, watchdog, debug), arbitrates and merges them, performs a quiesce handshake with the fabric, asserts all domain resets, then releases them in staged order. The power-on release follows the same staged order.

---
 rtl/rst_ctrl_pkg.sv | 20 ++
 rtl/reset_req_capture.sv | 30 +++
 rtl/reset_sequence_controller.sv | 173 +++++++++++++++++
 tb/tb_reset_sequence_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_ctrl_pkg.sv
// Shared types and helpers for the run-time reset sequence controller.
package rst_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUIESCE  = 3'd1,
    HOLD     = 3'd2,
    STEP_ICN = 3'd3,
    STEP_PER = 3'd4
  } rst_ctrl_state_t;

  // Counter must hold the largest of the three cycle lengths minus one.
  function automatic int ctr_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m >= 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_req_capture.sv
// Rising-edge capture of reset requests into a sticky pending mask.
module reset_req_capture #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               async_reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               clr,
  output logic [NUM_REQ-1:0] pending
);

  logic [NUM_REQ-1:0] req_q_r;
  logic [NUM_REQ-1:0] pending_r;
  logic [NUM_REQ-1:0] rise_s;

  assign rise_s  = req & ~req_q_r;
  assign pending = pending_r;

  // Edge detect and pending mask; a new edge on the clearing cycle survives.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      req_q_r   <= {NUM_REQ{1'b0}};
      pending_r <= {NUM_REQ{1'b0}};
    end else begin
      req_q_r   <= req;
      pending_r <= (clr ? {NUM_REQ{1'b0}} : pending_r) | rise_s;
    end
  end

endmodule

// File: rtl/reset_sequence_controller.sv
// Merges reset requests, quiesces the fabric and releases domain resets in order.
// Optional feature: RST_CTRL_QUIESCE_TIMEOUT_EN bounds the quiesce wait.
module reset_sequence_controller
  import rst_ctrl_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STEP_CYCLES     = 32,
  parameter int QUIESCE_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               async_reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] req_ack,
  output logic               quiesce_req,
  input  logic               quiesce_ack,
  input  logic               cause_clr,
  output logic               intercnct_reset,
  output logic               periferal_reset,
  output logic               processor_reset,
  output logic               busy,
  output logic [NUM_REQ-1:0] reset_cause,
  output logic               quiesce_timeout
);

  localparam int CW = ctr_width(HOLD_CYCLES, STEP_CYCLES, QUIESCE_TIMEOUT);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);

  rst_ctrl_state_t    state_r, state_s;
  logic [CW-1:0]      ctr_r;
  logic [NUM_REQ-1:0] pending_s;
  logic               hold_entry_s;
  logic               icn_s, per_s, proc_s;
  logic               icn_r, per_r, proc_r, qreq_r, busy_r;
  logic [NUM_REQ-1:0] ack_r, cause_r;

  reset_req_capture #(.NUM_REQ(NUM_REQ)) u_capture (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .req          (req),
    .clr          (hold_entry_s),
    .pending      (pending_s)
  );

`ifdef RST_CTRL_QUIESCE_TIMEOUT_EN
  localparam logic [CW-1:0] QT_LAST = CW'(QUIESCE_TIMEOUT - 1);
  logic timeout_hit_s;
  logic timeout_r;
`endif

  // Next-state selection; hold_entry_s marks the merge/ack edge.
  always_comb begin
    state_s      = state_r;
    hold_entry_s = 1'b0;
`ifdef RST_CTRL_QUIESCE_TIMEOUT_EN
    timeout_hit_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (pending_s != {NUM_REQ{1'b0}}) state_s = QUIESCE;
        else                              state_s = IDLE;
      end
      QUIESCE: begin
        if (quiesce_ack) begin
          state_s      = HOLD;
          hold_entry_s = 1'b1;
        end
`ifdef RST_CTRL_QUIESCE_TIMEOUT_EN
        else if (ctr_r == QT_LAST) begin
          state_s       = HOLD;
          hold_entry_s  = 1'b1;
          timeout_hit_s = 1'b1;
        end
`endif
        else begin
          state_s = QUIESCE;
        end
      end
      HOLD: begin
        if (ctr_r == HOLD_LAST) state_s = STEP_ICN;
        else                    state_s = HOLD;
      end
      STEP_ICN: begin
        if (ctr_r == STEP_LAST) state_s = STEP_PER;
        else                    state_s = STEP_ICN;
      end
      STEP_PER: begin
        if (ctr_r == STEP_LAST) state_s = IDLE;
        else                    state_s = STEP_PER;
      end
      default: state_s = HOLD;
    endcase
  end

  // Domain reset levels for the state being entered, so outputs stay registered.
  always_comb begin
    icn_s  = 1'b1;
    per_s  = 1'b1;
    proc_s = 1'b1;
    case (state_s)
      IDLE, QUIESCE: begin
        icn_s  = 1'b0;
        per_s  = 1'b0;
        proc_s = 1'b0;
      end
      HOLD: begin
        icn_s  = 1'b1;
        per_s  = 1'b1;
        proc_s = 1'b1;
      end
      STEP_ICN: icn_s = 1'b0;
      STEP_PER: begin
        icn_s = 1'b0;
        per_s = 1'b0;
      end
      default: begin
        icn_s  = 1'b1;
        per_s  = 1'b1;
        proc_s = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs; reset lands in HOLD for a staged power-on release.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_r <= HOLD;
      ctr_r   <= {CW{1'b0}};
      icn_r   <= 1'b1;
      per_r   <= 1'b1;
      proc_r  <= 1'b1;
      qreq_r  <= 1'b0;
      busy_r  <= 1'b1;
      ack_r   <= {NUM_REQ{1'b0}};
      cause_r <= {NUM_REQ{1'b0}};
    end else begin
      state_r <= state_s;
      ctr_r   <= (state_s != state_r) ? {CW{1'b0}} : ctr_r + CW'(1);
      icn_r   <= icn_s;
      per_r   <= per_s;
      proc_r  <= proc_s;
      qreq_r  <= (state_s == QUIESCE);
      busy_r  <= (state_s != IDLE);
      ack_r   <= hold_entry_s ? pending_s : {NUM_REQ{1'b0}};
      if (hold_entry_s) cause_r <= (cause_clr ? {NUM_REQ{1'b0}} : cause_r) | pending_s;
      else if (cause_clr) cause_r <= {NUM_REQ{1'b0}};
      else cause_r <= cause_r;
    end
  end

`ifdef RST_CTRL_QUIESCE_TIMEOUT_EN
  // Sticky timeout flag; a fresh timeout beats a coincident clear.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n)     timeout_r <= 1'b0;
    else if (timeout_hit_s) timeout_r <= 1'b1;
    else if (cause_clr)     timeout_r <= 1'b0;
    else                    timeout_r <= timeout_r;
  end
  assign quiesce_timeout = timeout_r;
`else
  assign quiesce_timeout = 1'b0;
`endif

  assign req_ack         = ack_r;
  assign quiesce_req     = qreq_r;
  assign intercnct_reset = icn_r;
  assign periferal_reset = per_r;
  assign processor_reset = proc_r;
  assign busy            = busy_r;
  assign reset_cause     = cause_r;

endmodule

// File: tb/tb_reset_sequence_controller.sv
// Bench for reset_sequence_controller: timeline reference model, directed and random requests.
module tb_reset_sequence_controller;

  localparam int N   = 4;
  localparam int H   = 16;
  localparam int S   = 32;
  localparam int QT  = 255;
  localparam int SEQ = H + 2 * S;

  logic         clk = 1'b0;
  logic         async_reset_n = 1'b0;
  logic         quiesce_ack = 1'b0;
  logic         cause_clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_ack, reset_cause;
  logic         quiesce_req, intercnct_reset, periferal_reset, processor_reset;
  logic         busy, quiesce_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a sequence is described by its HOLD entry edge seq_h;
  // every domain level follows from the distance to that edge.
  int           cyc = 0;
  int           seq_h = -100000;
  int           q_start = 0;
  bit           q_active = 1'b0;
  logic [N-1:0] m_pend = '0, m_cause = '0, m_prev = '0, m_ack = '0;
  logic         m_to = 1'b0;

  bit auto_ack = 1'b1;
  int ack_delay = 0;
  int qcnt = 0;

  always #5 clk = ~clk;

  reset_sequence_controller #(
    .NUM_REQ(N), .HOLD_CYCLES(H), .STEP_CYCLES(S), .QUIESCE_TIMEOUT(QT)
  ) dut (
    .clk            (clk),
    .async_reset_n  (async_reset_n),
    .req            (req),
    .req_ack        (req_ack),
    .quiesce_req    (quiesce_req),
    .quiesce_ack    (quiesce_ack),
    .cause_clr      (cause_clr),
    .intercnct_reset(intercnct_reset),
    .periferal_reset(periferal_reset),
    .processor_reset(processor_reset),
    .busy           (busy),
    .reset_cause    (reset_cause),
    .quiesce_timeout(quiesce_timeout)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] rise;
    bit           hit;
    int           k;
    @(posedge clk);
    cyc++;
    if (!async_reset_n) begin
      seq_h    = cyc;
      q_active = 1'b0;
      m_pend   = '0;
      m_cause  = '0;
      m_prev   = '0;
      m_ack    = '0;
      m_to     = 1'b0;
    end else begin
      rise   = req & ~m_prev;
      m_prev = req;
      m_ack  = '0;
      if (q_active) begin
        hit = 1'b0;
`ifdef RST_CTRL_QUIESCE_TIMEOUT_EN
        hit = !quiesce_ack && (cyc - q_start == QT);
`endif
        if (quiesce_ack || hit) begin
          m_ack    = m_pend;
          m_cause  = (cause_clr ? '0 : m_cause) | m_pend;
          m_to     = hit ? 1'b1 : (cause_clr ? 1'b0 : m_to);
          m_pend   = rise;
          seq_h    = cyc;
          q_active = 1'b0;
        end else begin
          m_pend = m_pend | rise;
          if (cause_clr) begin
            m_cause = '0;
            m_to    = 1'b0;
          end
        end
      end else begin
        if ((cyc - 1 - seq_h) >= SEQ && m_pend != '0) begin
          q_active = 1'b1;
          q_start  = cyc;
        end
        m_pend = m_pend | rise;
        if (cause_clr) begin
          m_cause = '0;
          m_to    = 1'b0;
        end
      end
    end
    @(negedge clk);
    k = cyc - seq_h;
    chk1("intercnct_reset", intercnct_reset, k < H);
    chk1("periferal_reset", periferal_reset, k < H + S);
    chk1("processor_reset", processor_reset, k < SEQ);
    chk1("busy", busy, q_active || (k < SEQ));
    chk1("quiesce_req", quiesce_req, q_active);
    chk("req_ack", req_ack, m_ack);
    chk("reset_cause", reset_cause, m_cause);
    chk1("quiesce_timeout", quiesce_timeout, m_to);
    qcnt        = quiesce_req ? qcnt + 1 : 0;
    quiesce_ack = auto_ack && quiesce_req && (qcnt > ack_delay);
  endtask

  task automatic wait_ack(input string tag, input int lim);
    int i;
    i = 0;
    while (req_ack == '0 && i < lim) begin
      step();
      i++;
    end
    chk1(tag, logic'(i < lim), 1'b1);
  endtask

  initial begin
    // Power-on staged release
    repeat (3) step();
    async_reset_n = 1'b1;
    repeat (SEQ + 5) step();
    chk1("po_busy_low", busy, 1'b0);

    // Single request, ack three cycles after quiesce_req
    ack_delay = 3;
    req = 4'b0100;
    step();
    step();
    req = 4'b0000;
    wait_ack("b_ack_seen", 200);
    chk("b_ack", req_ack, 4'b0100);
    chk("b_cause", reset_cause, 4'b0100);
    repeat (SEQ + 3) step();

    // Two sources rising together merge into one sequence
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    ack_delay = 0;
    req = 4'b1001;
    step();
    req = 4'b0000;
    wait_ack("c_ack_seen", 200);
    chk("c_ack", req_ack, 4'b1001);
    chk("c_cause", reset_cause, 4'b1001);
    repeat (SEQ + 3) step();

    // Request arriving during STEP_PER starts a second sequence
    req = 4'b0001;
    step();
    req = 4'b0000;
    wait_ack("d1_ack_seen", 200);
    repeat (H + S + 5) step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    wait_ack("d2_ack_seen", SEQ + 50);
    chk("d2_ack", req_ack, 4'b0010);
    repeat (SEQ + 3) step();

    // Random requests, clears and ack delays
    for (int i = 0; i < 1500; i++) begin
      step();
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 39) == 0) req[b] = ~req[b];
      end
      cause_clr = ($urandom_range(0, 49) == 0);
      if (!quiesce_req) ack_delay = $urandom_range(0, 6);
    end
    req = '0;
    cause_clr = 1'b0;
    ack_delay = 1;
    repeat (2 * SEQ + 20) step();

    // Fabric never acknowledges
    auto_ack = 1'b0;
    req = 4'b1000;
    step();
    req = 4'b0000;
    repeat (1000) step();
`ifdef RST_CTRL_QUIESCE_TIMEOUT_EN
    chk1("f_timeout_flag", quiesce_timeout, 1'b1);
`else
    chk1("f_still_quiesce", quiesce_req, 1'b1);
`endif
    auto_ack = 1'b1;
    repeat (SEQ + 20) step();
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;

    // Async reset in STEP_ICN
    req = 4'b0100;
    step();
    req = 4'b0000;
    wait_ack("g_ack_seen", 200);
    repeat (H + 5) step();
    #2;
    async_reset_n = 1'b0;
    #1;
    chk1("g_icn_async", intercnct_reset, 1'b1);
    chk1("g_per_async", periferal_reset, 1'b1);
    chk1("g_proc_async", processor_reset, 1'b1);
    chk("g_cause_async", reset_cause, 4'b0000);
    step();
    step();
    async_reset_n = 1'b1;
    repeat (SEQ + 5) step();
    chk1("g_busy_low", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
